// File: rtl/pdm_cic_decimator.sv
// Multi-channel PDM-to-PCM CIC decimator: per-channel integrators at the PDM rate,
// one shared comb chain time-multiplexed across channels, and a registered output FIFO.
module pdm_cic_decimator #(
  parameter int CHANNELS   = 1,
  parameter int STAGES     = 3,
  parameter int DECIM      = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [CHANNELS-1:0]         pdm_in,
  input  logic                        valid_in,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [CW-1:0]               out_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow_out
);

  localparam int L  = $clog2(DECIM);
  localparam int SL = STAGES * L;
  localparam int IW = SL + 2;
  localparam int SH = SL + 1 - OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + OUT_WIDTH;
  localparam logic [IW-1:0] P_POS = {2'b01, {SL{1'b0}}};

  typedef enum logic {S_IDLE, S_COMB} state_t;

  logic [IW-1:0]        r_integ     [CHANNELS][STAGES];
  logic [IW-1:0]        w_integ_nxt [CHANNELS][STAGES];
  logic [IW-1:0]        r_snap      [CHANNELS];
  logic [IW-1:0]        r_dly       [CHANNELS][STAGES];
  logic [IW-1:0]        w_dly_in    [STAGES];
  logic [IW-1:0]        w_comb_r;
  logic [IW-1:0]        w_clamp;
  logic [IW-1:0]        w_scaled;
  logic [L-1:0]         r_dcnt;
  logic                 w_tick;
  logic [2:0]           r_frames;
  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_chan, w_chan_nxt;
  logic                 w_comb_act, w_last;
  logic                 w_push, w_pop, w_full, w_wr_en;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [EW-1:0]        w_head;
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_cnt;
  logic                 r_ovf;

  // Integrator cascade uses each stage's next value so the last stage includes the current sample.
  always_comb begin : p_integ
    logic [IW-1:0] v_acc;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      v_acc = pdm_in[c] ? IW'(1) : '1;
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_acc = r_integ[c][k] + v_acc;
        w_integ_nxt[c][k] = v_acc;
      end
    end
  end

  assign w_tick = valid_in & (&r_dcnt);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_dcnt <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_snap[c] <= '0;
        for (int unsigned k = 0; k < STAGES; k++) r_integ[c][k] <= '0;
      end
    end else if (valid_in) begin
      r_dcnt  <= r_dcnt + 1'b1;
      r_integ <= w_integ_nxt;
      if (&r_dcnt) begin
        for (int unsigned c = 0; c < CHANNELS; c++) r_snap[c] <= w_integ_nxt[c][STAGES-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_comb_act  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_COMB;
          w_chan_nxt  = '0;
        end
      end
      S_COMB: begin
        w_comb_act = 1'b1;
        w_last     = (r_chan == CW'(CHANNELS - 1));
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_chan_nxt  = '0;
        end else begin
          w_chan_nxt = r_chan + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin : p_comb
    logic [IW-1:0] v_acc;
    v_acc = r_snap[r_chan];
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_dly_in[k] = v_acc;
      v_acc = v_acc - r_dly[r_chan][k];
    end
    w_comb_r = v_acc;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_frames <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned k = 0; k < STAGES; k++) r_dly[c][k] <= '0;
    end else if (w_comb_act) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        if (r_chan == CW'(c))
          for (int unsigned k = 0; k < STAGES; k++) r_dly[c][k] <= w_dly_in[k];
      if (w_last && (r_frames != 3'(STAGES))) r_frames <= r_frames + 1'b1;
    end
  end

  // Only the single value +2^SL is out of range; clamp it before the arithmetic shift.
  assign w_clamp  = (w_comb_r == P_POS) ? (P_POS - 1'b1) : w_comb_r;
  assign w_scaled = IW'($signed(w_clamp) >>> SH);
  assign w_push   = w_comb_act && (r_frames == 3'(STAGES));

  assign out_valid = (r_cnt != '0);
  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd];
  assign out_data  = out_valid ? w_head[OUT_WIDTH-1:0] : '0;
  assign out_chan  = out_valid ? w_head[EW-1:OUT_WIDTH] : '0;
  assign overflow_out = r_ovf;

  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[r_wr] <= {r_chan, w_scaled[OUT_WIDTH-1:0]};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: a 1-channel and a 2-channel instance checked against a
// direct-convolution CIC reference (boxcar^STAGES impulse response).
`timescale 1ns/1ps
module tb_pdm_cic_decimator;
  localparam int STAGES = 3;
  localparam int DECIM  = 64;
  localparam int OW     = 16;
  localparam int FD     = 4;
  localparam int SL     = STAGES * $clog2(DECIM);
  localparam int SH     = SL + 1 - OW;
  localparam int NC     = STAGES * (DECIM - 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:0] a_pdm = '0;
  logic a_valid = 1'b0, a_ready = 1'b1, a_ov, a_ovf;
  logic signed [OW-1:0] a_data;
  logic [0:0] a_chan;
  logic [1:0] b_pdm = '0;
  logic b_valid = 1'b0, b_ready = 1'b1, b_ov, b_ovf;
  logic signed [OW-1:0] b_data;
  logic [0:0] b_chan;

  pdm_cic_decimator #(.CHANNELS(1), .STAGES(STAGES), .DECIM(DECIM), .OUT_WIDTH(OW), .FIFO_DEPTH(FD)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .pdm_in(a_pdm), .valid_in(a_valid), .out_data(a_data),
    .out_chan(a_chan), .out_valid(a_ov), .out_ready(a_ready), .overflow_out(a_ovf));

  pdm_cic_decimator #(.CHANNELS(2), .STAGES(STAGES), .DECIM(DECIM), .OUT_WIDTH(OW), .FIFO_DEPTH(FD)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .pdm_in(b_pdm), .valid_in(b_valid), .out_data(b_data),
    .out_chan(b_chan), .out_valid(b_ov), .out_ready(b_ready), .overflow_out(b_ovf));

  int checks = 0;
  int failures = 0;
  int coef [NC];

  int h1[$], exp1[$], steps1;
  int h2a[$], h2b[$], exp2d[$], exp2c[$], steps2, tick2q[$];
  int c1d[$], c1c[$], c2d[$], c2c[$], c2t[$];

  always @(negedge clk) begin
    if (rst_n && a_ov && a_ready) begin c1d.push_back(int'(a_data)); c1c.push_back(int'(a_chan)); end
    if (rst_n && b_ov && b_ready) begin c2d.push_back(int'(b_data)); c2c.push_back(int'(b_chan)); c2t.push_back(cyc); end
  end

  function automatic void build_coef();
    int cur[$];
    int nxt[$];
    cur = {1};
    repeat (STAGES) begin
      nxt = {};
      for (int i = 0; i < cur.size() + DECIM - 1; i++) begin
        int s = 0;
        for (int j = 0; j < DECIM; j++) if (i - j >= 0 && i - j < cur.size()) s += cur[i-j];
        nxt.push_back(s);
      end
      cur = nxt;
    end
    for (int i = 0; i < NC; i++) coef[i] = cur[i];
  endfunction

  // Filter output at the newest sample of x, clamped and scaled to OW bits.
  function automatic int cic_ref(input int x[$]);
    longint r = 0;
    int t = x.size() - 1;
    for (int j = 0; j < NC && j <= t; j++) r += longint'(coef[j]) * x[t-j];
    if (r == (longint'(1) << SL)) r = r - 1;
    return int'(r >>> SH);
  endfunction

  function automatic void clear_models();
    h1 = {}; exp1 = {}; steps1 = 0;
    h2a = {}; h2b = {}; exp2d = {}; exp2c = {}; steps2 = 0; tick2q = {};
    c1d = {}; c1c = {}; c2d = {}; c2c = {}; c2t = {};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive1(input logic b, input int gap);
    a_pdm = b; a_valid = 1'b1;
    h1.push_back(b ? 1 : -1); steps1++;
    if (steps1 % DECIM == 0 && steps1 / DECIM > STAGES) exp1.push_back(cic_ref(h1));
    @(posedge clk); #1;
    if (gap > 0) begin a_valid = 1'b0; idle(gap); end
  endtask

  task automatic drive2(input logic [1:0] b, input int gap);
    b_pdm = b; b_valid = 1'b1;
    h2a.push_back(b[0] ? 1 : -1); h2b.push_back(b[1] ? 1 : -1); steps2++;
    if (steps2 % DECIM == 0) begin
      tick2q.push_back(cyc);
      if (steps2 / DECIM > STAGES) begin
        exp2c.push_back(0); exp2d.push_back(cic_ref(h2a));
        exp2c.push_back(1); exp2d.push_back(cic_ref(h2b));
      end
    end
    @(posedge clk); #1;
    if (gap > 0) begin b_valid = 1'b0; idle(gap); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    idle(3);
    rst_n = 1'b1;
    clear_models();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b want=0", a_ov); end
    checks++; if (a_data !== '0) begin failures++; $display("FAIL reset_a_data got=%0d want=0", a_data); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL reset_a_ovf got=%b want=0", a_ovf); end
    checks++; if (b_ov !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b want=0", b_ov); end
    checks++; if (b_chan !== '0) begin failures++; $display("FAIL reset_b_chan got=%0d want=0", b_chan); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_models();
  endtask

  task automatic test_const_one();
    a_ready = 1'b1;
    for (int i = 0; i < 3 * DECIM; i++) drive1(1'b1, 15);
    idle(4);
    checks++; if (c1d.size() != 0) begin failures++; $display("FAIL one_warmup count=%0d want=0", c1d.size()); end
    for (int i = 0; i < 2 * DECIM; i++) drive1(1'b1, 15);
    idle(4);
    checks++; if (c1d.size() != 2) begin failures++; $display("FAIL one_count got=%0d want=2", c1d.size()); end
    for (int i = 0; i < c1d.size() && i < exp1.size(); i++) begin
      checks++; if (c1d[i] != 32767 || c1c[i] != 0) begin failures++; $display("FAIL one_value[%0d] got=%0d/ch%0d want=32767/ch0", i, c1d[i], c1c[i]); end
      checks++; if (c1d[i] != exp1[i]) begin failures++; $display("FAIL one_model[%0d] got=%0d want=%0d", i, c1d[i], exp1[i]); end
    end
  endtask

  task automatic test_const_zero();
    do_reset();
    for (int i = 0; i < 6 * DECIM; i++) drive1(1'b0, 0);
    a_valid = 1'b0; idle(4);
    checks++; if (c1d.size() != 3) begin failures++; $display("FAIL zero_count got=%0d want=3", c1d.size()); end
    for (int i = 0; i < c1d.size(); i++) begin
      checks++; if (c1d[i] != -32768) begin failures++; $display("FAIL zero_value[%0d] got=%0d want=-32768", i, c1d[i]); end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 6 * DECIM; i++) drive1(logic'(i % 2 == 0), 0);
    a_valid = 1'b0; idle(4);
    checks++; if (c1d.size() != 3) begin failures++; $display("FAIL alt_count got=%0d want=3", c1d.size()); end
    for (int i = 0; i < c1d.size(); i++) begin
      checks++; if (c1d[i] != 0) begin failures++; $display("FAIL alt_value[%0d] got=%0d want=0", i, c1d[i]); end
    end
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      dens = $urandom_range(5, 95);
      for (int i = 0; i < DECIM; i++) begin
        a_ready = logic'($urandom_range(0, 1));
        drive1(logic'($urandom_range(1, 100) <= dens), $urandom_range(0, 2));
      end
    end
    a_valid = 1'b0; a_ready = 1'b1; idle(10);
    checks++; if (c1d.size() != exp1.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", c1d.size(), exp1.size()); end
    for (int i = 0; i < c1d.size() && i < exp1.size(); i++) begin
      checks++; if (c1d[i] != exp1[i]) begin failures++; $display("FAIL rand_model[%0d] got=%0d want=%0d", i, c1d[i], exp1[i]); end
    end
  endtask

  task automatic test_two_channel();
    do_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 5 * DECIM; i++) drive2(2'b01, 0);
    b_valid = 1'b0; idle(4);
    checks++; if (c2d.size() != 4) begin failures++; $display("FAIL two_count got=%0d want=4", c2d.size()); end
    for (int i = 0; i < c2d.size() && i < exp2d.size(); i++) begin
      checks++; if (c2c[i] != i % 2 || c2d[i] != ((i % 2 == 0) ? 32767 : -32768)) begin
        failures++; $display("FAIL two_value[%0d] got=%0d/ch%0d want=%0d/ch%0d", i, c2d[i], c2c[i], (i % 2 == 0) ? 32767 : -32768, i % 2); end
      checks++; if (c2d[i] != exp2d[i] || c2c[i] != exp2c[i]) begin failures++; $display("FAIL two_model[%0d] got=%0d want=%0d", i, c2d[i], exp2d[i]); end
    end
    if (c2t.size() >= 2 && tick2q.size() >= 4) begin
      checks++; if (c2t[0] != tick2q[3] + 2) begin failures++; $display("FAIL two_latency got=%0d want=%0d", c2t[0] - tick2q[3], 2); end
      checks++; if (c2t[1] != c2t[0] + 1) begin failures++; $display("FAIL two_spacing got=%0d want=1", c2t[1] - c2t[0]); end
    end
  endtask

  task automatic test_overflow();
    int head0;
    do_reset();
    a_ready = 1'b1;
    for (int i = 0; i < 3 * DECIM; i++) drive1(logic'($urandom_range(0, 1)), 0);
    a_ready = 1'b0;
    head0 = 0;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < DECIM; i++) drive1(logic'($urandom_range(0, 1)), 0);
      a_valid = 1'b0; idle(3);
      if (f == 0) head0 = int'(a_data);
      checks++; if (a_ov !== 1'b1) begin failures++; $display("FAIL ovf_valid_held f=%0d got=%b want=1", f, a_ov); end
      if (f == 3) begin checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", a_ovf); end end
      if (f == 4) begin checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", a_ovf); end end
    end
    checks++; if (int'(a_data) != head0) begin failures++; $display("FAIL ovf_head_stable got=%0d want=%0d", a_data, head0); end
    checks++; if (exp1.size() > 0 && head0 != exp1[0]) begin failures++; $display("FAIL ovf_head_value got=%0d want=%0d", head0, exp1[0]); end
    a_ready = 1'b1; idle(10);
    checks++; if (c1d.size() != FD) begin failures++; $display("FAIL ovf_drain_count got=%0d want=%0d", c1d.size(), FD); end
    for (int i = 0; i < c1d.size() && i < exp1.size(); i++) begin
      checks++; if (c1d[i] != exp1[i]) begin failures++; $display("FAIL ovf_drain[%0d] got=%0d want=%0d", i, c1d[i], exp1[i]); end
    end
    checks++; if (a_ov !== 1'b0 || a_ovf !== 1'b1) begin failures++; $display("FAIL ovf_after got=%b/%b want=0/1", a_ov, a_ovf); end
  endtask

  task automatic test_reset_mid_comb();
    do_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 4 * DECIM; i++) drive2(2'($urandom_range(0, 3)), 0);
    b_valid = 1'b0;
    idle(1);
    checks++; if (b_ov !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b want=1", b_ov); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (b_ov !== 1'b0 || b_data !== '0 || b_chan !== '0 || b_ovf !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%0d/%0d/%b want=0/0/0/0", b_ov, b_data, b_chan, b_ovf); end
    idle(2);
    rst_n = 1'b1;
    clear_models();
    for (int i = 0; i < 3 * DECIM; i++) drive2(2'($urandom_range(0, 3)), 0);
    b_valid = 1'b0; idle(4);
    checks++; if (c2d.size() != 0) begin failures++; $display("FAIL midrst_warmup count=%0d want=0", c2d.size()); end
    for (int i = 0; i < DECIM; i++) drive2(2'($urandom_range(0, 3)), 0);
    b_valid = 1'b0; idle(4);
    checks++; if (c2d.size() != 2) begin failures++; $display("FAIL midrst_count got=%0d want=2", c2d.size()); end
    for (int i = 0; i < c2d.size() && i < exp2d.size(); i++) begin
      checks++; if (c2d[i] != exp2d[i] || c2c[i] != exp2c[i]) begin
        failures++; $display("FAIL midrst_model[%0d] got=%0d/ch%0d want=%0d/ch%0d", i, c2d[i], c2c[i], exp2d[i], exp2c[i]); end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    build_coef();
    clear_models();
    test_reset();
    test_const_one();
    test_const_zero();
    test_alternating();
    test_random();
    test_two_channel();
    test_overflow();
    test_reset_mid_comb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Parametrised multi-channel PDM-to-PCM decimator built as a CIC filter. It sits between the microphone clock and strobe generator and the audio processing chain, and generalises the single-channel 8-bit FIR decimator. It adds configurable channel count, CIC order, decimation ratio, output width, a warm-up blanking period and a buffered valid/ready output with overflow reporting.

## Interface
- CHANNELS, 1: number of PDM channels. Range 1..4.
- STAGES, 3: CIC order, applied to both integrators and combs. Range 1..5.
- DECIM, 64: decimation ratio. Must be a power of two, ≥ 2*CHANNELS.
- OUT_WIDTH, 16: PCM output width. Must be ≤ STAGES*log2(DECIM)+1.
- FIFO_DEPTH, 4: output buffer entries. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk_in  input  1  system clock (98.3 MHz audio clock domain).
- rst_in  input  1  asynchronous active-low reset.
- pdm_in  input  CHANNELS  PDM bit per channel; sampled only when valid_in=1.
- valid_in  input  1  single-cycle PDM step strobe; may be high on every cycle.
- out_data  output  OUT_WIDTH  signed PCM sample at the FIFO head.
- out_chan  output  max(1,$clog2(CHANNELS))  channel index of out_data.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry when out_valid && out_ready.
- overflow_out  output  1  sticky; set when a sample is dropped.

## Operation
- L = log2(DECIM). Internal width IW = STAGES*L+2, two's complement.
- Input mapping: bit 1 → +1, bit 0 → −1.
- Integrators:
  - STAGES cascaded accumulators per channel, IW bits, wrap modulo 2^IW.
  - Update only on valid_in.
- Decimation counter counts valid_in from 0 to DECIM−1, then wraps to 0.
  - Tick = valid_in while the count is DECIM−1.
  - On a tick, the snapshot register per channel captures the last integrator's next value, i.e. the value including this sample.
- FSM IDLE→COMB→IDLE:
  - IDLE: a tick moves the FSM to COMB with chan=0.
  - COMB: one channel per cycle. The cycle passes that channel's snapshot through STAGES cascaded combs in one combinational chain, updates that channel's comb delay registers, and pushes one result. chan increments; after CHANNELS−1 the FSM returns to IDLE.
  - valid_in during COMB keeps updating the integrators and does not disturb COMB.
- Result scaling:
  - The comb result r lies in [−2^(STAGES*L), +2^(STAGES*L)].
  - +2^(STAGES*L) clamps to 2^(STAGES*L)−1.
  - out = r >>> (STAGES*L+1−OUT_WIDTH), arithmetic shift.
- Warm-up:
  - The first STAGES decimation frames after reset run the combs but push nothing.
  - A 3-bit frame counter saturates at STAGES.
- FIFO:
  - Stores {chan, data}. Registered (not fall-through).
  - Push and pop in the same cycle are both honoured, including when full.
  - A push while full and not popping drops the new entry and sets overflow_out. Stored entries are unchanged.
- Reset (asserted at any time, including mid-COMB) immediately clears all of the following:
  - integrators, combs, snapshots and counters;
  - FSM to IDLE;
  - FIFO to empty;
  - outputs: out_valid=0, out_data=0, out_chan=0, overflow_out=0.

## Timing
- Tick in cycle T gives channel c pushed at the end of cycle T+1+c, and visible with out_valid=1 from cycle T+2+c.
- Latency from the final valid_in of a frame to channel 0 on the output is 2 cycles.
- out_data and out_chan are stable while out_valid && !out_ready.
- Pop occurs on the edge where out_valid && out_ready.
- overflow_out rises in the cycle after the dropped push and is cleared only by reset.
- Throughput: CHANNELS samples per DECIM valid_in strobes.

## Test plan
- Defaults, pdm_in=1 constant, valid_in every 16 cycles, out_ready=1: exactly 3 frames produce no output, then every output is 32767 with out_chan=0.
- Defaults, pdm_in=0 constant: after warm-up, every output is −32768.
- Defaults, pdm_in alternating 1,0 per valid_in: after warm-up, every output is exactly 0.
- CHANNELS=2, ch0=1 and ch1=0: outputs alternate (chan0, 32767) then (chan1, −32768), with chan1 exactly one cycle after chan0. The first out_valid arrives 2 cycles after the tick strobe.
- out_ready=0 for 6 post-warm-up frames with FIFO_DEPTH=4: out_valid is held and overflow_out=1 after the 5th frame. Raising out_ready then drains exactly 4 entries in order, and the head value does not change while stalled.
- Assert rst_in low during COMB of CHANNELS=2: all outputs are 0 on the following cycle. After release, warm-up blanks 3 frames again.
